// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with saturating arithmetic, Z/V/N flags and an
// optional iterative multiply (build with ALU_PIPE_MUL_EN to enable op 0xA).
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_a/in_b/in_op
// operation input; out_valid/out_ready/out_data/out_err result output;
// flag_z/flag_v/flag_n condition flags; busy while a multiply iterates.
module alu_pipe #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_n,
    output logic             busy
);

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    function automatic logic [WIDTH-1:0] red_sum(input logic [2*WIDTH-1:0] ab);
        logic [WIDTH-1:0] acc;
        logic [7:0]       bt;
        acc = '0;
        for (int i = 0; i < 2*WIDTH/8; i++) begin
            bt  = ab[8*i +: 8];
            acc = acc + {{(WIDTH-8){bt[7]}}, bt};
        end
        return acc;
    endfunction

    function automatic logic [WIDTH-1:0] paddsb(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        logic [3:0]       na;
        logic [3:0]       nb;
        logic [4:0]       s;
        r = '0;
        for (int i = 0; i < WIDTH/4; i++) begin
            na = a[4*i +: 4];
            nb = b[4*i +: 4];
            s  = {na[3], na} + {nb[3], nb};
            // sign bits disagree in the 5-bit sum => 4-bit overflow
            if (s[4] != s[3])
                r[4*i +: 4] = s[4] ? 4'h8 : 4'h7;
            else
                r[4*i +: 4] = s[3:0];
        end
        return r;
    endfunction

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_err_q, out_err_d;
    logic             z_q, z_d, v_q, v_d, n_q, n_d;

    logic [WIDTH-1:0] res;
    logic             res_err, res_legal, res_vn, res_v, is_mul;
    logic [WIDTH-1:0] sum, dif;
    logic [SHW-1:0]   sh;
    logic [2*WIDTH-1:0] rot;
    logic             ovf_add, ovf_sub;

    logic             idle, mul_done, accept;
    logic [WIDTH-1:0] mul_res;

    assign sum     = in_a + in_b;
    assign dif     = in_a - in_b;
    assign sh      = in_b[SHW-1:0];
    assign rot     = {in_a, in_a} >> sh;
    assign ovf_add = (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                     (sum[WIDTH-1] != in_a[WIDTH-1]);
    assign ovf_sub = (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                     (dif[WIDTH-1] != in_a[WIDTH-1]);

    always_comb begin
        res       = '0;
        res_err   = 1'b0;
        res_legal = 1'b1;
        res_vn    = 1'b0;
        res_v     = 1'b0;
        is_mul    = 1'b0;
        case (in_op)
            4'h0: begin
                res_vn = 1'b1;
                res_v  = ovf_add;
                res    = ovf_add ? (in_a[WIDTH-1] ? SMIN : SMAX) : sum;
                res_err = ovf_add;
            end
            4'h1: begin
                res_vn = 1'b1;
                res_v  = ovf_sub;
                res    = ovf_sub ? (in_a[WIDTH-1] ? SMIN : SMAX) : dif;
                res_err = ovf_sub;
            end
            4'h2: res = in_a ^ in_b;
            4'h3: res = red_sum({in_b, in_a});
            4'h4: res = in_a << sh;
            4'h5: res = $signed(in_a) >>> sh;
            4'h6: res = rot[WIDTH-1:0];
            4'h7: res = paddsb(in_a, in_b);
            4'h8: res = {in_a[WIDTH-1:8], in_b[7:0]};
            4'h9: res = {in_b[7:0], in_a[WIDTH-9:0]};
`ifdef ALU_PIPE_MUL_EN
            4'hA: is_mul = 1'b1;
`endif
            default: begin
                res_legal = 1'b0;
                res_err   = 1'b1;
            end
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;

    assign idle     = (state_q == S_IDLE);
    assign busy     = (state_q == S_MUL);
    assign mul_done = busy && (cnt_q == SHW'(WIDTH-1));
    assign mul_res  = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d  = S_MUL;
                    mcand_d  = in_a;
                    mplier_d = in_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_MUL: begin
                acc_d    = mul_res;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (mul_done)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`else
    assign idle     = 1'b1;
    assign busy     = 1'b0;
    assign mul_done = 1'b0;
    assign mul_res  = '0;
`endif

    assign in_ready = idle && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_err_d   = out_err_q;
        z_d         = z_q;
        v_d         = v_q;
        n_d         = n_q;
        if (accept && !is_mul) begin
            out_valid_d = 1'b1;
            out_data_d  = res;
            out_err_d   = res_err;
            if (res_legal)
                z_d = (res == '0);
            if (res_vn) begin
                v_d = res_v;
                n_d = res[WIDTH-1];
            end
        end else if (mul_done) begin
            // output register is free here: IDLE only accepted the MUL
            // once the previous result had been taken
            out_valid_d = 1'b1;
            out_data_d  = mul_res;
            out_err_d   = 1'b0;
            z_d         = (mul_res == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            z_q         <= 1'b0;
            v_q         <= 1'b0;
            n_q         <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_err_q   <= out_err_d;
            z_q         <= z_d;
            v_q         <= v_d;
            n_q         <= n_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_err   = out_err_q;
    assign flag_z    = z_q;
    assign flag_v    = v_q;
    assign flag_n    = n_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed testbench for alu_pipe: vector table plus handshake,
// back-pressure, reset and (when ALU_PIPE_MUL_EN is defined) multiply cases.
module tb_alu_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_err;
    logic        flag_z;
    logic        flag_v;
    logic        flag_n;
    logic        busy;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err),
        .flag_z(flag_z), .flag_v(flag_v), .flag_n(flag_n),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        e;
        logic        z;
        logic        v;
        logic        n;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] d,
                        input logic e, input logic z,
                        input logic v, input logic n);
        vec_t t;
        t.op = op; t.a = a; t.b = b; t.d = d;
        t.e = e; t.z = z; t.v = v; t.n = n;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] d,
                           input logic e, input logic z,
                           input logic v, input logic n);
        chk({tag, " valid"}, 32'(out_valid), 32'd1);
        chk({tag, " data"}, 32'(out_data), 32'(d));
        chk({tag, " err"}, 32'(out_err), 32'(e));
        chk({tag, " Z"}, 32'(flag_z), 32'(z));
        chk({tag, " V"}, 32'(flag_v), 32'(v));
        chk({tag, " N"}, 32'(flag_n), 32'(n));
    endtask

    task automatic drive(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " out_data"}, 32'(out_data), 32'd0);
        chk({tag, " out_err"}, 32'(out_err), 32'd0);
        chk({tag, " flags"}, 32'({flag_z, flag_v, flag_n}), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;

        //    op    a        b        data     e  z  v  n
        addv(4'h0, 16'h7FFF, 16'h0001, 16'h7FFF, 1, 0, 1, 0);
        addv(4'h1, 16'h0005, 16'h0005, 16'h0000, 0, 1, 0, 0);
        addv(4'h2, 16'hFFFF, 16'h00FF, 16'hFF00, 0, 0, 0, 0);
        addv(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 0, 0, 0, 1);
        addv(4'h7, 16'h7878, 16'h1919, 16'h7878, 0, 0, 0, 1);
        addv(4'h3, 16'h0102, 16'h0304, 16'h000A, 0, 0, 0, 1);
        addv(4'h5, 16'h8000, 16'h0003, 16'hF000, 0, 0, 0, 1);
        addv(4'h6, 16'h0001, 16'h0001, 16'h8000, 0, 0, 0, 1);
        addv(4'h6, 16'h1234, 16'h0004, 16'h4123, 0, 0, 0, 1);
        addv(4'h4, 16'h00F0, 16'h0014, 16'h0F00, 0, 0, 0, 1);
        addv(4'h5, 16'h4000, 16'h000F, 16'h0000, 0, 1, 0, 1);
        addv(4'h8, 16'h1234, 16'h00AB, 16'h12AB, 0, 0, 0, 1);
        addv(4'hF, 16'h0001, 16'h0002, 16'h0000, 1, 0, 0, 1);
`ifndef ALU_PIPE_MUL_EN
        addv(4'hA, 16'h0005, 16'h0003, 16'h0000, 1, 0, 0, 1);
`endif
        addv(4'h9, 16'h1234, 16'h00AB, 16'hAB34, 0, 0, 0, 1);
        addv(4'h1, 16'h8000, 16'h0001, 16'h8000, 1, 0, 1, 1);
        addv(4'h3, 16'hFFFF, 16'hFF80, 16'hFF7D, 0, 0, 1, 1);
        addv(4'h7, 16'h1234, 16'h4321, 16'h5555, 0, 0, 1, 1);
        addv(4'h1, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1, 0, 1, 0);
        addv(4'h2, 16'h1234, 16'h1234, 16'h0000, 0, 1, 1, 0);
        addv(4'hB, 16'h0000, 16'h0000, 16'h0000, 1, 1, 1, 0);
        addv(4'h0, 16'h8000, 16'hFFFF, 16'h8000, 1, 0, 1, 1);

        #12;
        chk_reset_state("reset");
        chk("reset in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        tick();

        foreach (vecs[i]) begin
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
            drive(vecs[i].op, vecs[i].a, vecs[i].b);
            tick();
            in_valid = 1'b0;
            chk_out($sformatf("v%0d op%h", i, vecs[i].op), vecs[i].d,
                    vecs[i].e, vecs[i].z, vecs[i].v, vecs[i].n);
        end

        tick();
        chk("drain out_valid", 32'(out_valid), 32'd0);

        // mid-run reset clears flags left set by the table
        rst = 1'b1;
        #2;
        chk_reset_state("rst2");
        rst = 1'b0;
        tick();

        // back-to-back, one result per cycle
        chk("b2b in_ready0", 32'(in_ready), 32'd1);
        drive(4'h1, 16'h0005, 16'h0005);
        tick();
        chk("b2b in_ready1", 32'(in_ready), 32'd1);
        chk_out("b2b sub", 16'h0000, 0, 1, 0, 0);
        drive(4'h2, 16'hFFFF, 16'h00FF);
        tick();
        in_valid = 1'b0;
        chk_out("b2b xor", 16'hFF00, 0, 0, 0, 0);
        tick();

        // back-pressure: result held, second op stalled
        out_ready = 1'b0;
        drive(4'h0, 16'h0001, 16'h0002);
        tick();
        drive(4'h9, 16'h1234, 16'h00AB);
        chk_out("bp first", 16'h0003, 0, 0, 0, 0);
        chk("bp in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        chk("bp hold data", 32'(out_data), 32'h0003);
        chk("bp hold valid", 32'(out_valid), 32'd1);
        chk("bp hold in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #1;
        chk("bp release in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk_out("bp second", 16'hAB34, 0, 0, 0, 0);
        tick();
        chk("bp retire", 32'(out_valid), 32'd0);

`ifdef ALU_PIPE_MUL_EN
        begin
            int n;
            drive(4'hA, 16'h0123, 16'h0010);
            tick();
            in_valid = 1'b0;
            chk("mul busy", 32'(busy), 32'd1);
            chk("mul in_ready", 32'(in_ready), 32'd0);
            n = 0;
            while (busy && n < 40) begin
                n++;
                tick();
            end
            chk("mul busy cycles", 32'(n), 32'd16);
            chk_out("mul", 16'h1230, 0, 0, 0, 0);
            tick();

            drive(4'hA, 16'h0123, 16'h0010);
            tick();
            in_valid = 1'b0;
            for (int k = 0; k < 7; k++) tick();
            chk("mul abort busy pre", 32'(busy), 32'd1);
            rst = 1'b1;
            #2;
            chk_reset_state("mul abort");
            rst = 1'b0;
            tick();
            chk("mul abort in_ready", 32'(in_ready), 32'd1);
            for (int k = 0; k < 12; k++) tick();
            chk("mul abort no result", 32'(out_valid), 32'd0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
